// File: rtl/fft16_radix4_sched.sv
// Sequencer for a shared radix-4 butterfly: loads 16 samples, runs two
// in-place radix-4 stages over the buffer, then streams X[0..15] in order.
//
// state | meaning
// LOAD  | accept 16 input samples into the buffer
// S0    | first radix-4 stage, step g = 0..3, no twiddles
// S1    | second radix-4 stage, step k = 0..3, twiddles k, 2k, 3k
// OUT   | stream results in natural frequency order
module fft16_radix4_sched #(
   parameter int DW  = 17,
   parameter int TWW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*DW-1:0]  in_data,
   output logic [8*DW-1:0]  bf_in,
   output logic [3*TWW-1:0] bf_rot,
   input  logic [8*DW-1:0]  bf_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*DW-1:0]  out_data,
   output logic             out_last,
   output logic             busy
);

   typedef enum logic [1:0] {LOAD, S0, S1, OUT} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic [1:0]      step, step_nxt;
   logic            load_we, bf_we;
   logic [3:0]      lane_addr [4];
   logic [3:0]      rot3;
   logic [2*DW-1:0] mem [16];

   // S0 walks a stride-4 column, S1 walks a contiguous row of the buffer.
   always_comb begin
      for (int q = 0; q < 4; q++) begin
         if (state == S1) lane_addr[q] = {step, 2'(q)};
         else             lane_addr[q] = {2'(q), step};
      end
   end

   assign rot3 = 4'(step) * 4'd3;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      step_nxt  = step;
      load_we   = 1'b0;
      bf_we     = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b0;
      out_data  = '0;
      bf_in     = '0;
      bf_rot    = '0;
      if (!rst) begin
         case (state)
            LOAD: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  load_we = 1'b1;
                  cnt_nxt = cnt + 4'd1;
                  if (cnt == 4'd15) begin
                     state_nxt = S0;
                     step_nxt  = 2'd0;
                  end
               end
            end
            S0, S1: begin
               busy     = 1'b1;
               bf_we    = 1'b1;
               step_nxt = step + 2'd1;
               for (int q = 0; q < 4; q++)
                  bf_in[2*DW*q +: 2*DW] = mem[lane_addr[q]];
               if (state == S1) begin
                  bf_rot = {TWW'(rot3), TWW'({1'b0, step, 1'b0}), TWW'(step)};
                  if (step == 2'd3) state_nxt = OUT;
               end else if (step == 2'd3) begin
                  state_nxt = S1;
               end
            end
            OUT: begin
               busy      = 1'b1;
               out_valid = 1'b1;
               out_last  = (cnt == 4'd15);
               // X[n] sits at 4*(n mod 4) + n div 4 after the in-place passes
               out_data  = mem[{cnt[1:0], cnt[3:2]}];
               if (out_ready) begin
                  cnt_nxt = cnt + 4'd1;
                  if (cnt == 4'd15) state_nxt = LOAD;
               end
            end
            default: state_nxt = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
         cnt   <= 4'd0;
         step  <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         step  <= step_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (load_we) mem[cnt] <= in_data;
      if (bf_we) begin
         for (int m = 0; m < 4; m++)
            mem[lane_addr[m]] <= bf_out[2*DW*m +: 2*DW];
      end
   end

endmodule

// File: tb/tb_fft16_radix4_sched.sv
// Bench for fft16_radix4_sched: ideal complex butterfly driven from bf_in/bf_rot,
// expected spectra from a two-stage decimation-in-time reference.
module tb_fft16_radix4_sched;
   localparam int DW  = 17;
   localparam int TWW = 8;
   localparam real PI = 3.14159265358979323846;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2*DW-1:0]  in_data = '0;
   logic [8*DW-1:0]  bf_in;
   logic [3*TWW-1:0] bf_rot;
   logic [8*DW-1:0]  bf_out;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [2*DW-1:0]  out_data;
   logic             out_last;
   logic             busy;

   int checks = 0;
   int failures = 0;
   logic [2*DW-1:0] samp [16];
   logic [2*DW-1:0] expv [16];

   fft16_radix4_sched #(.DW(DW), .TWW(TWW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .bf_in(bf_in), .bf_rot(bf_rot), .bf_out(bf_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy));

   always #5 clk = ~clk;

   // Ideal radix-4 butterfly: y[m] = sum_q W16^rot_q * x[q] * (-j)^(q*m), rounded once.
   function automatic logic [8*DW-1:0] bfly(input logic [8*DW-1:0] x, input logic [3*TWW-1:0] rot);
      real ar [4];
      real ai [4];
      real yr, yi, ang;
      logic signed [DW-1:0] re, im, ore, oim;
      logic [8*DW-1:0] res;
      int code;
      res = '0;
      for (int q = 0; q < 4; q++) begin
         re = x[2*DW*q+DW +: DW];
         im = x[2*DW*q +: DW];
         code = (q == 0) ? 0 : int'(rot[TWW*(q-1) +: TWW]);
         ang = -2.0 * PI * code / 16.0;
         ar[q] = $itor(re) * $cos(ang) - $itor(im) * $sin(ang);
         ai[q] = $itor(re) * $sin(ang) + $itor(im) * $cos(ang);
      end
      for (int m = 0; m < 4; m++) begin
         yr = 0.0;
         yi = 0.0;
         for (int q = 0; q < 4; q++) begin
            case ((q * m) % 4)
               0: begin yr = yr + ar[q]; yi = yi + ai[q]; end
               1: begin yr = yr + ai[q]; yi = yi - ar[q]; end
               2: begin yr = yr - ar[q]; yi = yi - ai[q]; end
               default: begin yr = yr - ai[q]; yi = yi + ar[q]; end
            endcase
         end
         ore = DW'(int'(yr));
         oim = DW'(int'(yi));
         res[2*DW*m +: 2*DW] = {ore, oim};
      end
      return res;
   endfunction

   assign bf_out = bfly(bf_in, bf_rot);

   // X[k + 4m] = sum_q W16^(qk) W4^(qm) Y_q[k], with Y_g = 4-point DFT of x[g + 4q].
   task automatic run_model();
      logic [2*DW-1:0] ys [16];
      logic [8*DW-1:0] lanes, res;
      for (int g = 0; g < 4; g++) begin
         for (int q = 0; q < 4; q++) lanes[2*DW*q +: 2*DW] = samp[g + 4*q];
         res = bfly(lanes, '0);
         for (int m = 0; m < 4; m++) ys[4*g + m] = res[2*DW*m +: 2*DW];
      end
      for (int k = 0; k < 4; k++) begin
         for (int q = 0; q < 4; q++) lanes[2*DW*q +: 2*DW] = ys[4*q + k];
         res = bfly(lanes, {8'(3*k), 8'(2*k), 8'(k)});
         for (int m = 0; m < 4; m++) expv[k + 4*m] = res[2*DW*m +: 2*DW];
      end
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input bit gaps);
      int i = 0;
      int cyc = 0;
      bit acc;
      while (i < 16 && cyc < 400) begin
         cyc++;
         in_data  = samp[i];
         in_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
         acc = in_valid && in_ready;
         tick();
         if (acc) i++;
      end
      in_valid = 1'b0;
      chk("load_count", 256'(i), 256'(16));
   endtask

   task automatic wait_out();
      int c = 0;
      while (!out_valid && c < 50) begin
         tick();
         c++;
      end
      chk("out_latency", 256'(c), 256'(8));
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      int cyc = 0;
      bit hs;
      while (n < 16 && cyc < 400) begin
         cyc++;
         chk("out_valid", 256'(out_valid), 256'(1));
         chk("out_data", 256'(out_data), 256'(expv[n]));
         chk("out_last", 256'(out_last), 256'(n == 15));
         chk("in_ready_out", 256'(in_ready), 256'(0));
         out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
         hs = out_ready;
         tick();
         if (hs) n++;
      end
      out_ready = 1'b0;
      chk("drain_count", 256'(n), 256'(16));
      chk("in_ready_after", 256'(in_ready), 256'(1));
      chk("out_valid_after", 256'(out_valid), 256'(0));
   endtask

   task automatic set_impulse();
      for (int i = 0; i < 16; i++) begin
         samp[i] = (i == 0) ? {DW'(1), DW'(0)} : '0;
         expv[i] = {DW'(1), DW'(0)};
      end
   endtask

   task automatic set_random();
      int vr, vi;
      for (int i = 0; i < 16; i++) begin
         vr = int'($urandom_range(2000)) - 1000;
         vi = int'($urandom_range(2000)) - 1000;
         samp[i] = {DW'(vr), DW'(vi)};
      end
      run_model();
   endtask

   initial begin
      // reset outputs
      tick();
      tick();
      chk("rst_in_ready", 256'(in_ready), 256'(0));
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_bf_in", 256'(bf_in), 256'(0));
      chk("rst_bf_rot", 256'(bf_rot), 256'(0));
      chk("rst_out_data", 256'(out_data), 256'(0));
      chk("rst_out_last", 256'(out_last), 256'(0));
      rst = 1'b0;
      #1;

      // ramp frame with in_valid held: ready window, schedule and latency
      for (int i = 0; i < 16; i++) samp[i] = {DW'(i), DW'(0)};
      run_model();
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = samp[i];
         chk("load_ready", 256'(in_ready), 256'(1));
         tick();
      end
      for (int c = 1; c <= 8; c++) begin
         chk("compute_busy", 256'(busy), 256'(1));
         chk("compute_no_out", 256'(out_valid), 256'(0));
         chk("compute_no_in", 256'(in_ready), 256'(0));
         if (c == 2) begin
            chk("s0_g1_bf_in", 256'(bf_in), 256'({samp[13], samp[9], samp[5], samp[1]}));
            chk("s0_g1_rot", 256'(bf_rot), 256'(0));
         end
         if (c == 7) chk("s1_k2_rot", 256'(bf_rot), 256'({8'd6, 8'd4, 8'd2}));
         if (c == 8) chk("s1_k3_rot", 256'(bf_rot), 256'({8'd9, 8'd6, 8'd3}));
         tick();
      end
      in_valid = 1'b0;
      chk("first_out_valid", 256'(out_valid), 256'(1));
      drain(1'b0);

      // impulse
      set_impulse();
      load_frame(1'b0);
      wait_out();
      drain(1'b0);

      // constant ones, with random backpressure
      for (int i = 0; i < 16; i++) begin
         samp[i] = {DW'(1), DW'(0)};
         expv[i] = (i == 0) ? {DW'(16), DW'(0)} : '0;
      end
      load_frame(1'b1);
      wait_out();
      drain(1'b1);

      // random frames
      for (int f = 0; f < 3; f++) begin
         set_random();
         load_frame(1'b1);
         wait_out();
         drain(1'b1);
      end

      // reset during S1 step k=1
      set_random();
      load_frame(1'b0);
      for (int c = 0; c < 5; c++) tick();
      chk("pre_rst_rot", 256'(bf_rot), 256'({8'd3, 8'd2, 8'd1}));
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 256'(busy), 256'(0));
      chk("mid_rst_bf_in", 256'(bf_in), 256'(0));
      chk("mid_rst_bf_rot", 256'(bf_rot), 256'(0));
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 256'(in_ready), 256'(1));
      chk("post_rst_busy", 256'(busy), 256'(0));
      for (int c = 0; c < 12; c++) begin
         chk("post_rst_no_out", 256'(out_valid), 256'(0));
         tick();
      end
      set_impulse();
      load_frame(1'b0);
      wait_out();
      drain(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
